// File: rtl/rr_priority_encoder_if.sv
// Request/result handshake bundle for rr_priority_encoder.
// The encoder attaches via the slave modport; the requester/consumer side uses master.
interface rr_priority_encoder_if #(
  parameter int WIDTH = 16
) ();
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] req;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [WIDTH-1:0] out_grant;
  logic             out_none;

  modport slave (
    input  req, mode, in_valid, out_ready,
    output in_ready, out_valid, out_idx, out_grant, out_none
  );

  modport master (
    output req, mode, in_valid, out_ready,
    input  in_ready, out_valid, out_idx, out_grant, out_none
  );
endinterface

// File: rtl/rr_priority_encoder.sv
// Registered priority encoder with fixed (highest index wins) and round-robin modes,
// single result stage behind valid/ready handshakes on both sides.
module rr_priority_encoder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_priority_encoder_if.slave  bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] ptr_nxt;
  logic [WIDTH-1:0] onehot;
  logic             hit;
  logic             accept;
  int               cand;

  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] grant_q;
  logic             none_q;

  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_grant = grant_q;
  assign bus.out_none  = none_q;

  // Downward circular search from start; fixed mode is the same search anchored at the top bit.
  always_comb begin
    start = bus.mode ? ptr : TOP_IDX;
    hit   = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 0; k < WIDTH; k++) begin
      cand = int'(start) - k;
      if (cand < 0) cand = cand + WIDTH;
      if (!hit && bus.req[cand]) begin
        hit = 1'b1;
        win = IDX_W'(cand);
      end
    end
  end

  assign ptr_nxt = (win == '0) ? TOP_IDX : win - 1'b1;
  assign onehot  = {{(WIDTH-1){1'b0}}, 1'b1} << win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      grant_q <= '0;
      none_q  <= 1'b0;
      ptr     <= TOP_IDX;
    end else if (accept) begin
      valid_q <= 1'b1;
      idx_q   <= hit ? win : '0;
      grant_q <= hit ? onehot : '0;
      none_q  <= !hit;
      if (bus.mode && hit) ptr <= ptr_nxt;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end
endmodule
